mdu_unit: RTL and testbench
===========================

# mdu_unit

Multiply/divide unit for the EX stage of the five-stage MIPS pipeline. It consumes the forwarded register operands read from the register file and executes mult/multu/div/divu over a fixed multi-cycle latency, plus mthi/mtlo writes. It holds the architectural HI/LO registers and provides the mfhi/mflo read value that travels down the pipeline to register-file write-back. A registered `busy` flag tells the hazard unit to stall the next multiply/divide-class instruction in D.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10, busy cycles for div/divu (≥1)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; the only clock is clk
- start  in  1  EX holds a valid mult/multu/div/divu/mthi/mtlo this cycle
- op  in  3  1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 0 and 7 are no-ops
- A  in  32  rs operand (forwarded)
- B  in  32  rt operand (forwarded)
- rd_sel  in  1  0 selects LO, 1 selects HI for rd_data
- busy  out  1  registered; an operation is in flight
- rd_data  out  32  combinational HI or LO (architectural value)

## Operation
- States: IDLE, RUN. Down-counter cnt (4+ bits, sized to the larger parameter). Result registers hi_pend and lo_pend.
- IDLE, start=1, op∈{1..4}: compute the result in full, latch it into hi_pend/lo_pend, load cnt with the op's cycle count, go to RUN, set busy=1.
- IDLE, start=1, op=5: HI←A next edge. op=6: LO←A next edge. No busy.
- RUN: cnt decrements each edge. On the edge where cnt reaches 1, commit HI←hi_pend and LO←lo_pend, busy→0, return to IDLE.
- start while busy=1: ignored, including mthi/mtlo. The hazard unit must never issue it.
- Arithmetic:
  - mult: signed 32×32→64; HI=[63:32], LO=[31:0]. multu: unsigned.
  - div: LO=quotient truncated toward zero, HI=remainder with the sign of the dividend. divu: unsigned.
  - Divide by zero (B=0): operation still takes DIV_CYCLES; HI and LO are left unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
- rd_data reflects committed HI/LO only. Pending results are never visible.

## Timing
- Reset values: HI=0, LO=0, busy=0, state IDLE, cnt=0, rd_data=0.
- Reset during RUN: abort, no HI/LO write, busy=0 on the next edge.
- Start accepted at edge E0. busy=1 from after E0 through the edge E0+N, where N is the op's cycle count. HI/LO are updated at E0+N. busy=0 and new HI/LO are visible in the same cycle after E0+N.
- mthi/mtlo: the new value is visible on rd_data the cycle after the start edge.
- An mfhi/mflo read in the cycle a commit happens returns the old value. The hazard unit stalls mf* while start|busy, so this case does not occur in legal use.
- Back-to-back ops: a new start is accepted in the first cycle with busy=0.
- cnt never wraps. N=1 gives a single busy cycle.

## Test plan
- Reset, then mult A=0xFFFFFFFE(−2), B=3 -> busy high for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA; rd_data tracks rd_sel.
- multu A=0xFFFFFFFF, B=0xFFFFFFFF -> after 5 cycles HI=0xFFFFFFFE, LO=0x00000001.
- div A=0xFFFFFFF9(−7), B=2 -> busy for 10 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu with the same operands -> LO=0x7FFFFFFC, HI=1.
- mthi A=0x12345678, then mtlo A=0x9ABCDEF0 -> each value readable one cycle later. Then div with B=0 -> busy for 10 cycles, and HI/LO keep those two values.
- Start mult, pulse start (mtlo A=0xDEAD) at busy cycle 2 -> ignored; LO equals the mult result. Then div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- Start div, assert reset at busy cycle 4 -> busy=0 and HI=LO=0 on the next edge; no later commit occurs.

Source files
------------

// File: rtl/mdu_unit.sv
// rtl/mdu_unit.sv - multi-cycle multiply/divide unit holding architectural HI/LO
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        rd_sel,
  output logic        busy,
  output logic [31:0] rd_data
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo;
  logic [31:0]      hi_pend, lo_pend;
  logic             pend_wr;

  logic [63:0] mul_a, mul_b, prod;
  logic        sdiv;
  logic [31:0] div_n, div_d, div_q, div_r, q_res, r_res;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  // Full result computed in the issue cycle; signed divide runs on magnitudes and fixes signs after,
  // which also yields 0x80000000 for the INT_MIN / -1 overflow case without special handling.
  always_comb begin
    mul_a  = {{32{(op == OP_MULT) & A[31]}}, A};
    mul_b  = {{32{(op == OP_MULT) & B[31]}}, B};
    prod   = mul_a * mul_b;
    sdiv   = (op == OP_DIV);
    div_n  = (sdiv && A[31]) ? (~A + 32'd1) : A;
    div_d  = (sdiv && B[31]) ? (~B + 32'd1) : B;
    div_q  = (div_d == 32'd0) ? 32'd0 : div_n / div_d;
    div_r  = (div_d == 32'd0) ? 32'd0 : div_n % div_d;
    q_res  = (sdiv && (A[31] ^ B[31])) ? (~div_q + 32'd1) : div_q;
    r_res  = (sdiv && A[31]) ? (~div_r + 32'd1) : div_r;
    res_hi = 32'd0;
    res_lo = 32'd0;
    res_wr = 1'b0;
    case (op)
      OP_MULT, OP_MULTU: begin
        res_hi = prod[63:32];
        res_lo = prod[31:0];
        res_wr = 1'b1;
      end
      OP_DIV, OP_DIVU: begin
        res_hi = r_res;
        res_lo = q_res;
        res_wr = (B != 32'd0);
      end
      default: ;
    endcase
  end

  // Issue/run sequencing; pending result commits on the last busy edge, starts while busy are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      hi_pend <= 32'd0;
      lo_pend <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                hi_pend <= res_hi;
                lo_pend <= res_lo;
                pend_wr <= res_wr;
                cnt     <= (op == OP_MULT || op == OP_MULTU) ? MULT_N : DIV_N;
                state   <= S_RUN;
              end
              OP_MTHI: hi <= A;
              OP_MTLO: lo <= A;
              default: ;
            endcase
          end
        end
        default: begin
          if (cnt <= CNT_ONE) begin
            if (pend_wr) begin
              hi <= hi_pend;
              lo <= lo_pend;
            end
            cnt   <= '0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
      endcase
    end
  end

  assign busy    = (state == S_RUN);
  assign rd_data = rd_sel ? hi : lo;

endmodule

// File: tb/tb_mdu_unit.sv
// tb/tb_mdu_unit.sv - self-checking bench for mdu_unit with a behavioural HI/LO model
module tb_mdu_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        rd_sel = 1'b0;
  logic        busy;
  logic [31:0] rd_data;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0, p_hi = 32'd0, p_lo = 32'd0;
  logic        p_wr = 1'b0;
  int          m_left = 0;

  mdu_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .rd_sel(rd_sel), .busy(busy), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // model update at the edge, then compare DUT against it shortly after
  always @(posedge clk) begin
    longint sa, sb, q, r, p;
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && p_wr) begin
        m_hi = p_hi; m_lo = p_lo;
      end
    end else if (start) begin
      case (op)
        3'd1: begin
          sa = $signed(A); sb = $signed(B); p = sa * sb;
          p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1; m_left = MC;
        end
        3'd2: begin
          sa = {32'd0, A}; sb = {32'd0, B}; p = sa * sb;
          p_hi = p[63:32]; p_lo = p[31:0]; p_wr = 1; m_left = MC;
        end
        3'd3, 3'd4: begin
          if (op == 3'd3) begin sa = $signed(A); sb = $signed(B); end
          else begin sa = {32'd0, A}; sb = {32'd0, B}; end
          p_wr = (B != 0);
          if (p_wr) begin
            q = sa / sb; r = sa % sb;
            p_lo = q[31:0]; p_hi = r[31:0];
          end
          m_left = DC;
        end
        3'd5: m_hi = A;
        3'd6: m_lo = A;
        default: ;
      endcase
    end
    #1;
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("rd_data", rd_data, rd_sel ? m_hi : m_lo);
  end

  // issue one op and return how many cycles busy was seen high
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, output int n);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic read_both(input string name, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    rd_sel = 1'b1; #1;
    chk({name, "_hi"}, rd_data, exp_hi);
    chk({name, "_hi_model"}, m_hi, exp_hi);
    rd_sel = 1'b0; #1;
    chk({name, "_lo"}, rd_data, exp_lo);
    chk({name, "_lo_model"}, m_lo, exp_lo);
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    read_both("reset", 32'h0, 32'h0);

    issue(3'd1, 32'hFFFF_FFFE, 32'd3, n);
    chk("mult_cycles", n, MC);
    read_both("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
    chk("multu_cycles", n, MC);
    read_both("multu", 32'hFFFF_FFFE, 32'h0000_0001);

    issue(3'd3, 32'hFFFF_FFF9, 32'd2, n);
    chk("div_cycles", n, DC);
    read_both("div", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    issue(3'd4, 32'hFFFF_FFF9, 32'd2, n);
    chk("divu_cycles", n, DC);
    read_both("divu", 32'h0000_0001, 32'h7FFF_FFFC);

    // mthi then mtlo, each visible the cycle after the start edge
    issue(3'd5, 32'h1234_5678, 32'd0, n);
    chk("mthi_cycles", n, 0);
    rd_sel = 1'b1; #1; chk("mthi_val", rd_data, 32'h1234_5678);
    issue(3'd6, 32'h9ABC_DEF0, 32'd0, n);
    rd_sel = 1'b0; #1; chk("mtlo_val", rd_data, 32'h9ABC_DEF0);

    issue(3'd3, 32'd100, 32'd0, n);
    chk("div0_cycles", n, DC);
    read_both("div0", 32'h1234_5678, 32'h9ABC_DEF0);

    // mtlo during busy cycle 2 must be dropped
    @(negedge clk);
    start = 1'b1; op = 3'd1; A = 32'd7; B = 32'd6;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    @(negedge clk);
    start = 1'b1; op = 3'd6; A = 32'h0000_DEAD;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    n = 0;
    while (busy && n < 50) begin n++; @(negedge clk); end
    chk("ignored_drained", {31'd0, busy}, 32'd0);
    read_both("ignored", 32'h0, 32'd42);

    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, n);
    chk("ovf_cycles", n, DC);
    read_both("ovf", 32'h0, 32'h8000_0000);

    // back-to-back: mthi accepted right after commit
    issue(3'd5, 32'hCAFE_F00D, 32'd0, n);
    rd_sel = 1'b1; #1; chk("b2b_mthi", rd_data, 32'hCAFE_F00D);

    // reset in busy cycle 4 of a divide aborts it
    @(negedge clk);
    start = 1'b1; op = 3'd3; A = 32'd50; B = 32'd7;
    @(negedge clk);
    start = 1'b0; op = 3'd0;
    repeat (3) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    read_both("abort", 32'h0, 32'h0);
    repeat (15) @(negedge clk);
    read_both("abort_late", 32'h0, 32'h0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
